// File: rtl/dmem_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter that sits beside dmem on the data bus.
// Stores to ADDR_TX queue a byte; loads from ADDR_STAT return FIFO and line status.
module dmem_mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [11:0] ADDR_TX      = 12'hFF0,
    parameter logic [11:0] ADDR_STAT    = 12'hFF1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic        mmio_sel,
    output logic [31:0] q_mmio,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [15:0]      baud_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             push_req_s;
    logic             clr_req_s;
    logic             pop_s;
    logic             push_s;
    logic             full_s;
    logic             empty_s;
    logic             unused_s;

    assign unused_s = ^data[31:8];
    assign mmio_sel = (address_dmem == ADDR_TX) || (address_dmem == ADDR_STAT);
    assign uart_tx  = tx_q;
    assign tx_busy  = (state_q != IDLE);

    // FIFO handshake: a full FIFO still accepts a push when the FSM pops on the same edge
    always_comb begin
        push_req_s = wren && (address_dmem == ADDR_TX);
        clr_req_s  = wren && (address_dmem == ADDR_STAT);
        full_s     = (count_q == DEPTH_C);
        empty_s    = (count_q == CNT_ZERO);
        pop_s      = (state_q == IDLE) && !empty_s;
        push_s     = push_req_s && (!full_s || pop_s);
        count_d    = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
        ovf_d = ovf_q;
        if (clr_req_s) begin
            ovf_d = 1'b0;
        end else if (push_req_s && !push_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Status read mux
    always_comb begin
        if (address_dmem == ADDR_STAT) begin
            q_mmio = {16'h0000, 8'(count_q), 4'h0, ovf_q, tx_busy, full_s, empty_s};
        end else begin
            q_mmio = 32'h0000_0000;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            ovf_q    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= data[7:0];
        end
    end

    // Frame serializer; tx_q always carries the level of the bit being sent
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= 16'd0;
                    tx_q   <= 1'b1;
                    if (pop_s) begin
                        shift_q <= fifo_mem_q[rd_ptr_q];
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q    <= 16'd0;
                        bit_idx_q <= 3'd0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= 16'd0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= 16'd0;
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    baud_q  <= 16'd0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio_uart_tx.sv
// Bench for dmem_mmio_uart_tx: directed scenarios plus random bus traffic checked
// against a queue-based reference model and a line-level frame decoder.
module tb_dmem_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam logic [11:0] A_TX = 12'hFF0;
    localparam logic [11:0] A_ST = 12'hFF1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wren  = 1'b0;
    logic [11:0] address_dmem = 12'h000;
    logic [31:0] data = 32'h0;
    logic        mmio_sel;
    logic [31:0] q_mmio;
    logic        uart_tx;
    logic        tx_busy;

    int total = 0;
    int bad   = 0;

    // reference model state: queued bytes, frame in flight and its elapsed cycle
    bit [7:0] mq[$];
    bit       m_busy = 1'b0;
    int       m_t    = 0;
    bit [7:0] m_byte = 8'h00;
    bit       m_ovf  = 1'b0;
    bit [7:0] framed[$];

    // line decoder state
    bit [7:0] rxq[$];
    int       rx_cnt = -1;
    bit [7:0] rx_byte = 8'h00;
    int       busy_seen = 0;
    int       low_seen  = 0;

    always #5 clock = ~clock;

    dmem_mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_TX     (A_TX),
        .ADDR_STAT   (A_ST)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .data        (data),
        .wren        (wren),
        .mmio_sel    (mmio_sel),
        .q_mmio      (q_mmio),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_stat();
        int n = mq.size();
        return {16'h0000, 8'(n), 4'h0, m_ovf, m_busy, (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic exp_tx();
        int b;
        if (!m_busy) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    task automatic model_step();
        int  pre;
        bit  pop;
        if (reset) begin
            if (m_busy && m_t < 38) void'(framed.pop_back());
            mq.delete();
            m_busy = 1'b0;
            m_t    = 0;
            m_ovf  = 1'b0;
        end else begin
            pre = mq.size();
            pop = !m_busy && (pre != 0);
            if (m_busy) begin
                m_t++;
                if (m_t == 10 * CPB) m_busy = 1'b0;
            end
            if (pop) begin
                m_byte = mq.pop_front();
                framed.push_back(m_byte);
                m_busy = 1'b1;
                m_t    = 0;
            end
            if (wren && address_dmem == A_TX) begin
                if (pre < DEPTH || pop) mq.push_back(data[7:0]);
                else m_ovf = 1'b1;
            end
            if (wren && address_dmem == A_ST) m_ovf = 1'b0;
        end
    endtask

    task automatic rx_sample();
        if (reset) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (uart_tx === 1'b0) rx_cnt = 0;
        end else begin
            rx_cnt++;
            if ((rx_cnt % CPB) == 2 && rx_cnt >= 6 && rx_cnt <= 34)
                rx_byte[(rx_cnt - 6) / CPB] = uart_tx;
            if (rx_cnt == 38) begin
                check_eq("stopbit", 32'(uart_tx), 32'h1);
                rxq.push_back(rx_byte);
                rx_cnt = -1;
            end
        end
    endtask

    task automatic step(input logic w, input logic [11:0] a, input logic [31:0] d);
        wren = w;
        address_dmem = a;
        data = d;
        #1;
        check_eq("sel", 32'(mmio_sel), 32'((a == A_TX) || (a == A_ST)));
        check_eq("q", q_mmio, (a == A_ST) ? exp_stat() : 32'h0);
        @(posedge clock);
        model_step();
        #1;
        check_eq("tx", 32'(uart_tx), 32'(exp_tx()));
        check_eq("busy", 32'(tx_busy), 32'(m_busy));
        rx_sample();
        if (tx_busy) busy_seen++;
        if (!uart_tx) low_seen++;
    endtask

    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        wren = 1'b0;
        address_dmem = a;
        #1;
        check_eq(tag, q_mmio, exp);
    endtask

    task automatic compare_rx(input string tag);
        check_eq({tag, "_nframes"}, 32'(rxq.size()), 32'(framed.size()));
        for (int i = 0; i < rxq.size() && i < framed.size(); i++)
            check_eq({tag, "_byte"}, 32'(rxq[i]), 32'(framed[i]));
        rxq.delete();
        framed.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        logic        rw;
        logic [11:0] ra;

        // 1: reset
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        model_step();
        #1;
        check_eq("rst_tx", 32'(uart_tx), 32'h1);
        check_eq("rst_busy", 32'(tx_busy), 32'h0);
        reset = 1'b0;
        peek("rst_stat", A_ST, 32'h0000_0001);

        // 2: single frame of 0xA5
        busy_seen = 0;
        low_seen  = 0;
        step(1'b1, A_TX, 32'h1234_56A5);
        check_eq("s2_pre", 32'(uart_tx), 32'h1);
        step(1'b0, A_ST, 32'h0);
        check_eq("s2_lat", 32'(uart_tx), 32'h0);
        repeat (45) step(1'b0, A_ST, 32'h0);
        check_eq("s2_busy_cycles", 32'(busy_seen), 32'd40);
        check_eq("s2_low_cycles", 32'(low_seen), 32'd20);
        check_eq("s2_nframes", 32'(rxq.size()), 32'd1);
        check_eq("s2_byte", 32'(rxq[0]), 32'hA5);
        peek("s2_stat", A_ST, 32'h0000_0001);
        compare_rx("s2");

        // 3: overfill the FIFO
        for (int i = 1; i <= 10; i++) step(1'b1, A_TX, 32'(i));
        peek("s3_stat", A_ST, 32'h0000_080E);

        // 4: overflow clear
        step(1'b1, A_ST, $urandom);
        peek("s4_stat", A_ST, 32'h0000_0806);
        repeat (400) step(1'b0, 12'h000, 32'h0);
        check_eq("s3_nframes", 32'(rxq.size()), 32'd9);
        for (int i = 0; i < 9 && i < rxq.size(); i++)
            check_eq("s3_order", 32'(rxq[i]), 32'(i + 1));
        compare_rx("s3");

        // 5: reset during second data bit of the first frame
        step(1'b1, A_TX, 32'h11);
        step(1'b1, A_TX, 32'h22);
        step(1'b1, A_TX, 32'h33);
        repeat (8) step(1'b0, 12'h000, 32'h0);
        reset = 1'b1;
        step(1'b0, 12'h000, 32'h0);
        reset = 1'b0;
        check_eq("s5_tx", 32'(uart_tx), 32'h1);
        peek("s5_stat", A_ST, 32'h0000_0001);
        low_seen = 0;
        repeat (60) step(1'b0, 12'h000, 32'h0);
        check_eq("s5_no_frames", 32'(low_seen), 32'd0);
        compare_rx("s5");

        // 6: non-MMIO address and read of TX address
        step(1'b1, 12'h010, 32'h0000_00FF);
        wren = 1'b0;
        address_dmem = 12'h010;
        #1;
        check_eq("s6_sel010", 32'(mmio_sel), 32'h0);
        check_eq("s6_q010", q_mmio, 32'h0);
        peek("s6_qtx", A_TX, 32'h0);
        check_eq("s6_seltx", 32'(mmio_sel), 32'h1);
        peek("s6_stat", A_ST, 32'h0000_0001);

        // random bus traffic
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            r = $urandom_range(0, 9);
            if (r < 5) ra = A_TX;
            else if (r < 7) ra = A_ST;
            else if (r < 8) ra = 12'h010;
            else ra = 12'($urandom);
            rw = ($urandom_range(0, 99) < ((i < 600) ? 40 : 4));
            step(rw, ra, $urandom);
        end
        reset = 1'b0;
        repeat (500) step(1'b0, A_ST, 32'h0);
        compare_rx("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
